apb_req_arbiter: RTL

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_req_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: two-requester round-robin APB master; APB_TIMEOUT_EN adds an ACCESS abort timer.
module apb_req_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [1:0]        req_i,
  input  logic [1:0]        write_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic last, owner, win;
  // on a tie the requester not served last wins
  assign win = (req_i[0] & req_i[1]) ? ~last : req_i[1];
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic tmo;
  assign tmo = cnt == CW'(TIMEOUT - 1);
`else
  assign err_o = 1'b0;
`endif
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
      last <= 1'b1;
      owner <= 1'b0;
      gnt_o <= '0;
      done_o <= '0;
      rdata_o <= '0;
      psel_o <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o <= 1'b0;
      paddr_o <= '0;
      pwdata_o <= '0;
`ifdef APB_TIMEOUT_EN
      err_o <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      gnt_o <= '0;
      done_o <= '0;
`ifdef APB_TIMEOUT_EN
      err_o <= 1'b0;
`endif
      case (state)
        IDLE: if (|req_i) begin
          pwrite_o <= write_i[win];
          paddr_o <= win ? addr1_i : addr0_i;
          pwdata_o <= win ? wdata1_i : wdata0_i;
          psel_o <= 1'b1;
          penable_o <= 1'b0;
          gnt_o <= win ? 2'b10 : 2'b01;
          owner <= win;
          last <= win;
          state <= SETUP;
        end
        SETUP: begin
          penable_o <= 1'b1;
          state <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        ACCESS: if (pready_i) begin
          psel_o <= 1'b0;
          penable_o <= 1'b0;
          done_o <= owner ? 2'b10 : 2'b01;
          if (!pwrite_o) rdata_o <= prdata_i;
          state <= IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo) begin
          psel_o <= 1'b0;
          penable_o <= 1'b0;
          done_o <= owner ? 2'b10 : 2'b01;
          err_o <= 1'b1;
          state <= IDLE;
        end else cnt <= cnt + 1'b1;
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule
